// File: rtl/load_store_unit.sv
// Load/store sequencer: IDLE -> ADDR -> ACCESS -> DONE, one memory access per request.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  input  logic [31:0] mem_rdata
);

  localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) << 2;
  localparam logic [2:0]  F3_B  = 3'b000;
  localparam logic [2:0]  F3_H  = 3'b001;
  localparam logic [2:0]  F3_W  = 3'b010;
  localparam logic [2:0]  F3_BU = 3'b100;
  localparam logic [2:0]  F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ADDR, ACCESS, DONE} state_t;

  state_t      state, state_next;
  logic        is_store_q;
  logic        write_q;
  logic        done_q;
  logic        undefined;
  logic        out_of_range;
  logic        misaligned;
  logic        fault_next;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_next;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ADDR;
      ADDR:    state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fault classification on the latched request, evaluated during ADDR
  always_comb begin
    undefined  = 1'b1;
    misaligned = 1'b0;
    case (mem_funct3)
      F3_B, F3_H, F3_W: undefined = 1'b0;
      F3_BU, F3_HU:     undefined = is_store_q;
      default:          undefined = 1'b1;
    endcase
    out_of_range = {2'b00, mem_addr} >= ADDR_LIMIT;
`ifdef LSU_MISALIGN_TRAP_EN
    misaligned = ((mem_funct3[1:0] == 2'b01) && mem_addr[0]) ||
                 ((mem_funct3 == F3_W) && (mem_addr[1:0] != 2'b00));
`else
    misaligned = 1'b0;
`endif
    fault_next = undefined | out_of_range | misaligned;
  end

  // Lane extraction and extension of the returned memory word
  always_comb begin
    lane_byte = mem_rdata[{mem_addr[1:0], 3'b000} +: 8];
    lane_half = mem_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (mem_funct3)
      F3_B:    load_next = {{24{lane_byte[7]}}, lane_byte};
      F3_BU:   load_next = {24'h000000, lane_byte};
      F3_H:    load_next = {{16{lane_half[15]}}, lane_half};
      F3_HU:   load_next = {16'h0000, lane_half};
      default: load_next = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done_q     <= 1'b0;
      write_q    <= 1'b0;
      fault      <= 1'b0;
      is_store_q <= 1'b0;
      load_data  <= 32'h0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_funct3 <= 3'b000;
    end else begin
      state   <= state_next;
      busy    <= (state_next != IDLE);
      done_q  <= (state == ACCESS);
      write_q <= (state == ADDR) && is_store_q && !fault_next;
      if (state == IDLE && start) begin
        is_store_q <= is_store;
        mem_funct3 <= funct3;
        mem_wdata  <= store_data;
        mem_addr   <= base + offset;
      end
      if (state == ADDR) fault <= fault_next;
      if (state == ACCESS && !is_store_q && !fault) load_data <= load_next;
    end
  end

  // Reset kills the strobes within the cycle it is raised
  assign done      = done_q & ~reset;
  assign mem_write = write_q & ~reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: scoreboard of expected completions plus a word memory model.
`timescale 1ns/1ps
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] base, offset, store_data;
  logic        busy, done, fault, mem_write;
  logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_funct3;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .store_data(store_data),
    .busy(busy), .done(done), .load_data(load_data), .fault(fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  // Memory model: 1024 words, lane placement done here
  logic [31:0] mem [0:1023];
  logic        in_range;
  assign in_range  = (mem_addr < 32'h1000);
  assign mem_rdata = in_range ? mem[mem_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (mem_write && in_range) begin
      case (mem_funct3)
        3'b000:  mem[mem_addr[11:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
        3'b001:  mem[mem_addr[11:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
        default: mem[mem_addr[11:2]] <= mem_wdata;
      endcase
    end
  end

  typedef struct {
    logic        fault;
    logic [31:0] load_data;
    int          writes;
    logic [31:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  typedef struct {
    logic        fault;
    logic [31:0] load_data;
    int          writes;
    logic [31:0] waddr;
    logic [31:0] wdata;
    int          write_cycle;
    int          latency;
  } obs_t;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] b;
    logic [31:0] o;
    logic [31:0] d;
  } txn_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_load;

  task automatic push_exp(input logic f, input logic [31:0] ld, input int w,
                          input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.fault = f; e.load_data = ld; e.writes = w; e.waddr = a; e.wdata = d;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * lane)) & 32'hFF;
    h = (w >> (16 * lane[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b ^ 32'h80) - 32'h80;
      3'b100:  return b;
      3'b001:  return (h ^ 32'h8000) - 32'h8000;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // Issue one request and watch it for a bounded number of cycles
  task automatic drive_txn(input txn_t t, output obs_t r);
    r = '{default: '0};
    r.latency = -1;
    r.write_cycle = -1;
    @(negedge clk);
    start = 1'b1; is_store = t.st; funct3 = t.f3; base = t.b; offset = t.o; store_data = t.d;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (mem_write) begin
        r.writes++; r.waddr = mem_addr; r.wdata = mem_wdata; r.write_cycle = k;
      end
      if (done) begin
        r.latency = k; r.fault = fault; r.load_data = load_data;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; is_store = 1'b1; funct3 = 3'b010;
    base = 32'h40; offset = 32'h0; store_data = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, fault, mem_write} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags busy/done/fault/mem_write=%b want 0000", {busy, done, fault, mem_write});
    end
    checks++;
    if (load_data !== 32'h0 || mem_addr !== 32'h0) begin
      failures++; $display("FAIL reset_data load_data=%h mem_addr=%h want 0/0", load_data, mem_addr);
    end
    checks++;
    if (mem_wdata !== 32'h0 || mem_funct3 !== 3'b000) begin
      failures++; $display("FAIL reset_wr mem_wdata=%h mem_funct3=%b want 0/000", mem_wdata, mem_funct3);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL reset_idle busy=%b done=%b want 0/0", busy, done);
    end
    last_load = 32'h0;
  endtask

  task automatic test_store_load;
    txn_t q[$]; obs_t r; exp_t e;
    q.push_back('{1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF});
    push_exp(1'b0, last_load, 1, 32'h104, 32'hDEADBEEF);
    q.push_back('{1'b0, 3'b010, 32'h100, 32'h4, 32'h0});
    last_load = 32'hDEADBEEF; push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
    foreach (q[i]) begin
      drive_txn(q[i], r); e = sb.pop_front();
      checks++;
      if (r.latency !== 3 || r.write_cycle !== (e.writes == 1 ? 2 : -1)) begin
        failures++; $display("FAIL store_load[%0d] timing latency=%0d write_cycle=%0d want 3/%0d", i, r.latency, r.write_cycle, (e.writes == 1 ? 2 : -1));
      end
      checks++;
      if (r.fault !== e.fault || r.load_data !== e.load_data) begin
        failures++; $display("FAIL store_load[%0d] result fault=%b load_data=%h want %b/%h", i, r.fault, r.load_data, e.fault, e.load_data);
      end
      checks++;
      if (r.writes !== e.writes || r.waddr !== e.waddr || r.wdata !== e.wdata) begin
        failures++; $display("FAIL store_load[%0d] write n=%0d addr=%h data=%h want %0d/%h/%h", i, r.writes, r.waddr, r.wdata, e.writes, e.waddr, e.wdata);
      end
    end
  endtask

  task automatic test_extend;
    txn_t q[$]; obs_t r; exp_t e;
    logic [2:0]  f3s  [8] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000, 3'b001, 3'b101, 3'b100};
    logic [31:0] offs [8] = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h1, 32'h0, 32'h2, 32'h0};
    logic [31:0] want [8] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F0, 32'h0000_7F01,
                              32'h0000_007F, 32'h0000_7F01, 32'h0000_80F0, 32'h0000_0001};
    q.push_back('{1'b1, 3'b010, 32'h200, 32'h0, 32'h80F0_7F01});
    push_exp(1'b0, last_load, 1, 32'h200, 32'h80F0_7F01);
    for (int i = 0; i < 8; i++) begin
      q.push_back('{1'b0, f3s[i], 32'h200, offs[i], 32'h0});
      last_load = want[i]; push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
    end
    foreach (q[i]) begin
      drive_txn(q[i], r); e = sb.pop_front();
      checks++;
      if (r.latency !== 3 || r.fault !== e.fault || r.load_data !== e.load_data) begin
        failures++; $display("FAIL extend[%0d] latency=%0d fault=%b load_data=%h want 3/%b/%h", i, r.latency, r.fault, r.load_data, e.fault, e.load_data);
      end
      checks++;
      if (r.writes !== e.writes || r.waddr !== e.waddr || r.wdata !== e.wdata) begin
        failures++; $display("FAIL extend[%0d] write n=%0d addr=%h data=%h want %0d/%h/%h", i, r.writes, r.waddr, r.wdata, e.writes, e.waddr, e.wdata);
      end
    end
  endtask

  task automatic test_range;
    txn_t q[$]; obs_t r; exp_t e;
    q.push_back('{1'b1, 3'b010, 32'hFFFF_FFFC, 32'h8, 32'h1234_5678});
    push_exp(1'b0, last_load, 1, 32'h4, 32'h1234_5678);
    q.push_back('{1'b0, 3'b010, 32'h0, 32'h4, 32'h0});
    last_load = 32'h1234_5678; push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
    q.push_back('{1'b0, 3'b010, 32'h1000, 32'h0, 32'h0});
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
    q.push_back('{1'b1, 3'b010, 32'hF00, 32'hFC, 32'hA5A5_A5A5});
    push_exp(1'b0, last_load, 1, 32'hFFC, 32'hA5A5_A5A5);
    q.push_back('{1'b0, 3'b010, 32'hFFC, 32'h0, 32'h0});
    last_load = 32'hA5A5_A5A5; push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
    q.push_back('{1'b1, 3'b010, 32'hFFC, 32'h4, 32'h0BAD_0BAD});
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
    q.push_back('{1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, 32'h0});
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
    foreach (q[i]) begin
      drive_txn(q[i], r); e = sb.pop_front();
      checks++;
      if (r.latency !== 3 || r.fault !== e.fault || r.load_data !== e.load_data) begin
        failures++; $display("FAIL range[%0d] latency=%0d fault=%b load_data=%h want 3/%b/%h", i, r.latency, r.fault, r.load_data, e.fault, e.load_data);
      end
      checks++;
      if (r.writes !== e.writes || r.waddr !== e.waddr || r.wdata !== e.wdata) begin
        failures++; $display("FAIL range[%0d] write n=%0d addr=%h data=%h want %0d/%h/%h", i, r.writes, r.waddr, r.wdata, e.writes, e.waddr, e.wdata);
      end
    end
  endtask

  task automatic test_undefined;
    txn_t q[$]; obs_t r; exp_t e;
    q.push_back('{1'b1, 3'b110, 32'h100, 32'h0, 32'h1111_1111});
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
    q.push_back('{1'b1, 3'b100, 32'h100, 32'h0, 32'h2222_2222});
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
    q.push_back('{1'b1, 3'b101, 32'h100, 32'h0, 32'h3333_3333});
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
    q.push_back('{1'b0, 3'b100, 32'h104, 32'h0, 32'h0});
    last_load = 32'h0000_00EF; push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
    q.push_back('{1'b0, 3'b011, 32'h104, 32'h0, 32'h0});
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
    q.push_back('{1'b0, 3'b111, 32'h104, 32'h0, 32'h0});
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
    foreach (q[i]) begin
      drive_txn(q[i], r); e = sb.pop_front();
      checks++;
      if (r.latency !== 3 || r.fault !== e.fault || r.load_data !== e.load_data) begin
        failures++; $display("FAIL undefined[%0d] latency=%0d fault=%b load_data=%h want 3/%b/%h", i, r.latency, r.fault, r.load_data, e.fault, e.load_data);
      end
      checks++;
      if (r.writes !== e.writes) begin
        failures++; $display("FAIL undefined[%0d] write count=%0d want %0d", i, r.writes, e.writes);
      end
    end
  endtask

  task automatic test_misalign;
    txn_t q[$]; obs_t r; exp_t e;
    q.push_back('{1'b1, 3'b010, 32'h100, 32'h0, 32'hCAFE_F00D});
    push_exp(1'b0, last_load, 1, 32'h100, 32'hCAFE_F00D);
    q.push_back('{1'b0, 3'b010, 32'h100, 32'h2, 32'h0});
    q.push_back('{1'b0, 3'b101, 32'h100, 32'h1, 32'h0});
    q.push_back('{1'b0, 3'b001, 32'h100, 32'h3, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
`else
    last_load = 32'hCAFE_F00D; push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
    last_load = 32'h0000_F00D; push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
    last_load = 32'hFFFF_CAFE; push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
`endif
    q.push_back('{1'b0, 3'b000, 32'h100, 32'h3, 32'h0});
    last_load = 32'hFFFF_FFCA; push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
    q.push_back('{1'b1, 3'b010, 32'h100, 32'h2, 32'h1122_3344});
    q.push_back('{1'b0, 3'b010, 32'h100, 32'h0, 32'h0});
`ifdef LSU_MISALIGN_TRAP_EN
    push_exp(1'b1, last_load, 0, 32'h0, 32'h0);
    last_load = 32'hCAFE_F00D; push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
`else
    push_exp(1'b0, last_load, 1, 32'h102, 32'h1122_3344);
    last_load = 32'h1122_3344; push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
`endif
    foreach (q[i]) begin
      drive_txn(q[i], r); e = sb.pop_front();
      checks++;
      if (r.latency !== 3 || r.fault !== e.fault || r.load_data !== e.load_data) begin
        failures++; $display("FAIL misalign[%0d] latency=%0d fault=%b load_data=%h want 3/%b/%h", i, r.latency, r.fault, r.load_data, e.fault, e.load_data);
      end
      checks++;
      if (r.writes !== e.writes || r.waddr !== e.waddr || r.wdata !== e.wdata) begin
        failures++; $display("FAIL misalign[%0d] write n=%0d addr=%h data=%h want %0d/%h/%h", i, r.writes, r.waddr, r.wdata, e.writes, e.waddr, e.wdata);
      end
    end
  endtask

  // start held high: one request per 4-cycle round trip
  task automatic test_back_to_back;
    exp_t e;
    int writes = 0, dones = 0, busy_low = 0;
    for (int i = 0; i < 3; i++) push_exp(1'b0, last_load, 1, 32'h3A0, 32'h0000_0077);
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; base = 32'h3A0; offset = 32'h0; store_data = 32'h77;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 11) start = 1'b0;
      if (k < 12 && !busy) busy_low++;
      if (mem_write) begin
        writes++;
        checks++;
        if (mem_addr !== 32'h3A0 || mem_wdata !== 32'h77) begin
          failures++; $display("FAIL back_to_back write addr=%h data=%h want 3a0/77", mem_addr, mem_wdata);
        end
      end
      if (done) begin
        dones++;
        checks++;
        if (sb.size() == 0) begin
          failures++; $display("FAIL back_to_back extra done at cycle %0d", k);
        end else begin
          e = sb.pop_front();
          if (fault !== e.fault || load_data !== e.load_data) begin
            failures++; $display("FAIL back_to_back result fault=%b load_data=%h want %b/%h", fault, load_data, e.fault, e.load_data);
          end
        end
      end
    end
    checks++;
    if (writes !== 3 || dones !== 3) begin
      failures++; $display("FAIL back_to_back counts writes=%0d dones=%0d want 3/3", writes, dones);
    end
    checks++;
    if (busy_low !== 3) begin
      failures++; $display("FAIL back_to_back idle cycles=%0d want 3", busy_low);
    end
    sb.delete();
  endtask

  task automatic test_reset_abort;
    int writes = 0, dones = 0;
    @(negedge clk);
    start = 1'b1; is_store = 1'b1; funct3 = 3'b010; base = 32'h380; offset = 32'h0; store_data = 32'h5555_AAAA;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mem_write !== 1'b1) begin
      failures++; $display("FAIL abort_pre mem_write=%b want 1", mem_write);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL abort_same_cycle mem_write=%b done=%b want 0/0", mem_write, done);
    end
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || load_data !== 32'h0) begin
      failures++; $display("FAIL abort_next busy=%b done=%b load_data=%h want 0/0/0", busy, done, load_data);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (mem_write) writes++;
      if (done) dones++;
    end
    checks++;
    if (writes !== 0 || dones !== 0 || mem[32'h380 >> 2] === 32'h5555_AAAA) begin
      failures++; $display("FAIL abort_after writes=%0d dones=%0d mem=%h want 0/0/not 5555aaaa", writes, dones, mem[32'h380 >> 2]);
    end
    last_load = 32'h0;
  endtask

  task automatic test_random;
    txn_t q[$]; obs_t r; exp_t e;
    logic [31:0] words [8];
    logic [2:0]  f3s [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [31:0] addr, b;
    int          idx;
    for (int i = 0; i < 8; i++) begin
      words[i] = $urandom;
      q.push_back('{1'b1, 3'b010, 32'h300 + 32'(4 * i), 32'h0, words[i]});
      push_exp(1'b0, last_load, 1, 32'h300 + 32'(4 * i), words[i]);
    end
    for (int i = 0; i < 16; i++) begin
      idx = int'($urandom_range(0, 7));
      f3 = f3s[$urandom_range(0, 4)];
      if (f3 == 3'b010) lane = 2'b00;
      else if (f3[0]) lane = {1'($urandom_range(0, 1)), 1'b0};
      else lane = 2'($urandom_range(0, 3));
      addr = 32'h300 + 32'(4 * idx) + 32'(lane);
      b = $urandom;
      q.push_back('{1'b0, f3, b, addr - b, 32'h0});
      last_load = ext_model(words[idx], lane, f3);
      push_exp(1'b0, last_load, 0, 32'h0, 32'h0);
    end
    foreach (q[i]) begin
      drive_txn(q[i], r); e = sb.pop_front();
      checks++;
      if (r.latency !== 3 || r.fault !== e.fault || r.load_data !== e.load_data) begin
        failures++; $display("FAIL random[%0d] latency=%0d fault=%b load_data=%h want 3/%b/%h", i, r.latency, r.fault, r.load_data, e.fault, e.load_data);
      end
      checks++;
      if (r.writes !== e.writes || r.waddr !== e.waddr || r.wdata !== e.wdata) begin
        failures++; $display("FAIL random[%0d] write n=%0d addr=%h data=%h want %0d/%h/%h", i, r.writes, r.waddr, r.wdata, e.writes, e.waddr, e.wdata);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    base = 32'h0; offset = 32'h0; store_data = 32'h0; last_load = 32'h0;
    test_reset();
    test_store_load();
    test_extend();
    test_range();
    test_undefined();
    test_misalign();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
